// File: rtl/stim_traffic_pkg.sv
// Shared types and constants for the stim_traffic_gen pattern generator:
// FSM/mode enums, Fibonacci LFSR tap masks and the walking-one seed.
package stim_traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_FLAGS = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_COUNT     = 2'd0,
        MODE_LFSR      = 2'd1,
        MODE_WALK      = 2'd2,
        MODE_COUNT_ALT = 2'd3
    } mode_e;

    // Maximal-length polynomials: x^8+x^6+x^5+x^4+1, x^16+x^15+x^13+x^4+1,
    // x^32+x^22+x^2+x+1; bit i of the mask taps state bit i.
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    localparam logic [31:0] WALK_ONE_SEED = 32'h0000_0001;

    // Widths without a table entry fall back to the two top bits as taps.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            32'sd8:  lfsr_taps = {24'h00_0000, LFSR_TAPS_8};
            32'sd16: lfsr_taps = {16'h0000, LFSR_TAPS_16};
            32'sd32: lfsr_taps = LFSR_TAPS_32;
            default: lfsr_taps = (width >= 32'sd2) ? (32'h0000_0003 << (width - 32'sd2))
                                                   : 32'h0000_0001;
        endcase
    endfunction

endpackage

// File: rtl/stim_clk_en_div.sv
// Free-running clock-enable divider: div_en[k] pulses for one cycle in every
// 2^(k+1) cycles, derived from a DIV_STAGES-bit counter.
module stim_clk_en_div #(
    parameter int DIV_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DIV_STAGES-1:0] div_en
);

    logic [DIV_STAGES-1:0] cnt_r;
    logic [DIV_STAGES-1:0] tap_s;
    logic [DIV_STAGES-1:0] div_en_r;

    for (genvar k = 0; k < DIV_STAGES; k++) begin : g_tap
        assign tap_s[k] = &cnt_r[k:0];
    end

    // Counter and registered enables; the enable fires the cycle after the low bits wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= '0;
            div_en_r <= '0;
        end else begin
            cnt_r    <= cnt_r + DIV_STAGES'(1);
            div_en_r <= tap_s;
        end
    end

    assign div_en = div_en_r;

endmodule

// File: rtl/stim_traffic_gen.sv
// Stimulus traffic generator: IDLE -> WAIT -> BURST -> FLAGS with a ready/valid
// beat stream. Define STIM_TRAFFIC_GEN_LFSR_EN to enable the LFSR pattern (mode 1).
module stim_traffic_gen
    import stim_traffic_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int IDLE_LEN   = 256,
    parameter int BURST_LEN  = 65536,
    parameter int FLAG_W     = 4,
    parameter int DIV_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  repeat_en,
    input  logic [1:0]            mode,
    output logic [DATA_W-1:0]     data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [FLAG_W-1:0]     flags_out,
    output logic [7:0]            status_out,
    output logic [DIV_STAGES-1:0] div_en,
    output logic                  busy,
    output logic                  done_pulse
);

    localparam int WAIT_W = (IDLE_LEN  > 1) ? $clog2(IDLE_LEN)  : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(IDLE_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
    localparam logic [FLAG_W-1:0] FLAG_LAST   = {FLAG_W{1'b1}};
    localparam logic [FLAG_W-1:0] FLAG_PENULT = FLAG_LAST - FLAG_W'(1);

`ifdef STIM_TRAFFIC_GEN_LFSR_EN
    localparam logic [DATA_W-1:0] LFSR_MASK = DATA_W'(lfsr_taps(DATA_W));
`endif

    state_e              state_r;
    mode_e               mode_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [BEAT_W-1:0]   beat_cnt_r;
    logic [FLAG_W-1:0]   flag_cnt_r;
    logic [DATA_W-1:0]   data_r;
    logic [7:0]          status_r;
    logic                valid_r;
    logic                busy_r;
    logic                done_r;

    function automatic logic beat_parity(input logic [DATA_W-1:0] beat);
        beat_parity = ^beat;
    endfunction

    // Without the LFSR option, mode 1 falls into the counting default.
    function automatic logic [DATA_W-1:0] pattern_seed(input mode_e sel);
        case (sel)
`ifdef STIM_TRAFFIC_GEN_LFSR_EN
            MODE_LFSR: pattern_seed = {DATA_W{1'b1}};
`endif
            MODE_WALK: pattern_seed = DATA_W'(WALK_ONE_SEED);
            default:   pattern_seed = {DATA_W{1'b0}};
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] pattern_next(input mode_e sel,
                                                        input logic [DATA_W-1:0] beat);
        case (sel)
`ifdef STIM_TRAFFIC_GEN_LFSR_EN
            MODE_LFSR: pattern_next = {beat[DATA_W-2:0], ^(beat & LFSR_MASK)};
`endif
            MODE_WALK: pattern_next = (beat << 1'b1) | (beat >> (DATA_W - 1));
            default:   pattern_next = beat + DATA_W'(1);
        endcase
    endfunction

    // Main sequencer; stop outranks every transition but leaves data and status alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_COUNT;
            wait_cnt_r <= '0;
            beat_cnt_r <= '0;
            flag_cnt_r <= '0;
            data_r     <= '0;
            status_r   <= 8'h00;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (stop) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
            beat_cnt_r <= '0;
            flag_cnt_r <= '0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_WAIT;
                        mode_r     <= mode_e'(mode);
                        data_r     <= pattern_seed(mode_e'(mode));
                        wait_cnt_r <= '0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_r    <= ST_BURST;
                        wait_cnt_r <= '0;
                        valid_r    <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_BURST: begin
                    if (valid_r && ready_in) begin
                        data_r   <= pattern_next(mode_r, data_r);
                        status_r <= {status_r[6:0], beat_parity(data_r)};
                        if (beat_cnt_r == BEAT_LAST) begin
                            state_r    <= ST_FLAGS;
                            beat_cnt_r <= '0;
                            valid_r    <= 1'b0;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                        end
                    end
                end
                ST_FLAGS: begin
                    // flag_cnt_r wraps to zero on the final cycle of the phase
                    flag_cnt_r <= flag_cnt_r + FLAG_W'(1);
                    done_r     <= (flag_cnt_r == FLAG_PENULT);
                    if (flag_cnt_r == FLAG_LAST) begin
                        state_r <= repeat_en ? ST_WAIT : ST_IDLE;
                        busy_r  <= repeat_en;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    stim_clk_en_div #(
        .DIV_STAGES (DIV_STAGES)
    ) u_clk_en_div (
        .clk    (clk),
        .reset  (reset),
        .div_en (div_en)
    );

    assign data_out   = data_r;
    assign valid_out  = valid_r;
    assign flags_out  = flag_cnt_r;
    assign status_out = status_r;
    assign busy       = busy_r;
    assign done_pulse = done_r;

endmodule

// File: tb/tb_stim_traffic_gen.sv
// Self-checking bench for stim_traffic_gen: directed scenarios plus randomized
// start/stop/ready/reset traffic against a cycle-level behavioural model.
module tb_stim_traffic_gen;

    localparam int DATA_W     = 16;
    localparam int IDLE_LEN   = 4;
    localparam int BURST_LEN  = 8;
    localparam int FLAG_W     = 4;
    localparam int DIV_STAGES = 3;
    localparam int FLAG_N     = 1 << FLAG_W;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic                  stop = 1'b0;
    logic                  repeat_en = 1'b0;
    logic                  ready_in = 1'b0;
    logic [1:0]            mode = 2'd0;
    logic [DATA_W-1:0]     data_out;
    logic                  valid_out;
    logic [FLAG_W-1:0]     flags_out;
    logic [7:0]            status_out;
    logic [DIV_STAGES-1:0] div_en;
    logic                  busy;
    logic                  done_pulse;

    int n_cmp = 0;
    int n_mis = 0;

    // model: phase 0 idle, 1 wait, 2 burst, 3 flags
    int m_st = 0, m_wait = 0, m_beats = 0, m_flag = 0;
    int m_data = 0, m_status = 0, m_mode = 0, m_cyc = 0;
    int acc_q[$];

    stim_traffic_gen #(
        .DATA_W     (DATA_W),
        .IDLE_LEN   (IDLE_LEN),
        .BURST_LEN  (BURST_LEN),
        .FLAG_W     (FLAG_W),
        .DIV_STAGES (DIV_STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .repeat_en  (repeat_en),
        .mode       (mode),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .flags_out  (flags_out),
        .status_out (status_out),
        .div_en     (div_en),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_mode(input int md);
`ifdef STIM_TRAFFIC_GEN_LFSR_EN
        if (md == 1) return 1;
`endif
        if (md == 2) return 2;
        return 0;
    endfunction

    function automatic int pattern_seed(input int md);
        if (md == 1) return 65535;
        if (md == 2) return 1;
        return 0;
    endfunction

    // x^16+x^15+x^13+x^4+1: feed back the XOR of bits 16,15,13,4 (1-based) into bit 1.
    function automatic int pattern_next(input int md, input int d);
        int fb;
        if (md == 1) begin
            fb = ((d >> 15) ^ (d >> 14) ^ (d >> 12) ^ (d >> 3)) & 1;
            return ((d * 2) % 65536) + fb;
        end
        if (md == 2) return ((d * 2) % 65536) + (d / 32768);
        return (d + 1) % 65536;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_st = 0; m_wait = 0; m_beats = 0; m_flag = 0;
            m_data = 0; m_status = 0; m_mode = 0; m_cyc = 0;
        end else begin
            m_cyc++;
            if (stop) begin
                m_st = 0; m_wait = 0; m_beats = 0; m_flag = 0;
            end else begin
                case (m_st)
                    0: if (start) begin
                        m_st = 1; m_wait = 0;
                        m_mode = eff_mode(int'(mode));
                        m_data = pattern_seed(m_mode);
                    end
                    1: begin
                        m_wait++;
                        if (m_wait == IDLE_LEN) m_st = 2;
                    end
                    2: if (ready_in) begin
                        m_status = ((m_status * 2) + ($countones(m_data) % 2)) % 256;
                        m_data = pattern_next(m_mode, m_data);
                        m_beats++;
                        if (m_beats == BURST_LEN) begin
                            m_st = 3; m_beats = 0; m_flag = 0;
                        end
                    end
                    3: begin
                        if (m_flag == FLAG_N - 1) begin
                            m_flag = 0; m_wait = 0;
                            m_st = repeat_en ? 1 : 0;
                        end else begin
                            m_flag++;
                        end
                    end
                    default: m_st = 0;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        logic [DIV_STAGES-1:0] exp_div;
        for (int k = 0; k < DIV_STAGES; k++)
            exp_div[k] = (m_cyc > 0) && (m_cyc % (2 << k) == 0);
        check_eq("data_out", data_out, m_data);
        check_eq("valid_out", valid_out, m_st == 2);
        check_eq("busy", busy, m_st != 0);
        check_eq("done_pulse", done_pulse, (m_st == 3) && (m_flag == FLAG_N - 1));
        check_eq("flags_out", flags_out, (m_st == 3) ? m_flag : 0);
        check_eq("status_out", status_out, m_status);
        check_eq("div_en", div_en, exp_div);
    endtask

    // One clock: note acceptance/stall before the edge, then check after it.
    task automatic tick();
        logic              hold;
        logic [DATA_W-1:0] prev_data;
        hold = valid_out && !ready_in && !stop && !reset;
        prev_data = data_out;
        if (valid_out && ready_in && !stop && !reset) acc_q.push_back(int'(data_out));
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        if (hold) begin
            check_eq("stall_valid", valid_out, 1);
            check_eq("stall_data", data_out, prev_data);
        end
    endtask

    task automatic pulse_start(input int md);
        mode = 2'(md);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int c0, c1, c2, first_valid, dones, expv;

        tick();
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_data", data_out, 0);
        check_eq("rst_div", div_en, 0);
        reset = 1'b0;

        // divider pulse counts over 16 cycles after reset
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            c0 += int'(div_en[0]); c1 += int'(div_en[1]); c2 += int'(div_en[2]);
        end
        check_eq("div0_count", c0, 8);
        check_eq("div1_count", c1, 4);
        check_eq("div2_count", c2, 2);

        // basic burst timing
        ready_in = 1'b1;
        acc_q.delete();
        pulse_start(0);
        check_eq("busy_cycle1", busy, 1);
        first_valid = -1; dones = 0;
        for (int i = 2; i < 80 && busy; i++) begin
            tick();
            if (valid_out && first_valid < 0) first_valid = i;
            dones += int'(done_pulse);
        end
        check_eq("first_valid_cycle", first_valid, 5);
        check_eq("done_count", dones, 1);
        check_eq("idle_after_run", busy, 0);
        check_eq("basic_beats", acc_q.size(), 8);
        for (int j = 0; j < acc_q.size(); j++) check_eq("basic_seq", acc_q[j], j);

        // alternating ready stalls
        acc_q.delete();
        pulse_start(0);
        for (int i = 0; i < 120 && busy; i++) begin
            ready_in = (i % 2 == 0);
            tick();
        end
        ready_in = 1'b1;
        check_eq("stall_beats", acc_q.size(), 8);
        for (int j = 0; j < acc_q.size(); j++) check_eq("stall_seq", acc_q[j], j);

        // repeat continues counting into the second burst
        repeat_en = 1'b1;
        acc_q.delete();
        pulse_start(0);
        for (int i = 0; i < 200 && acc_q.size() < 16; i++) tick();
        check_eq("repeat_beats", acc_q.size(), 16);
        for (int j = 0; j < acc_q.size(); j++) check_eq("repeat_seq", acc_q[j], j);
        check_eq("repeat_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat_en = 1'b0;
        check_eq("stop_idle", busy, 0);

        // stop together with start on the 3rd beat
        acc_q.delete();
        pulse_start(0);
        for (int i = 0; i < 100 && acc_q.size() < 2; i++) tick();
        check_eq("third_beat_valid", valid_out, 1);
        check_eq("third_beat_data", data_out, 2);
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        check_eq("stop_valid", valid_out, 0);
        check_eq("stop_busy", busy, 0);
        check_eq("stop_data_hold", data_out, 2);
        tick();
        tick();
        check_eq("start_ignored", busy, 0);
        check_eq("stop_beats", acc_q.size(), 2);

        // reset in the middle of a walking-one burst
        pulse_start(2);
        for (int i = 0; i < 20 && !valid_out; i++) tick();
        check_eq("walk_first", data_out, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_valid", valid_out, 0);
        check_eq("midrst_data", data_out, 0);
        tick();

        // mode 1: LFSR sequence, or plain counting without the option
        repeat_en = 1'b1;
        acc_q.delete();
        pulse_start(1);
        for (int i = 0; i < 2000 && acc_q.size() < 100; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat_en = 1'b0;
        check_eq("mode1_beats", acc_q.size() >= 100, 1);
`ifdef STIM_TRAFFIC_GEN_LFSR_EN
        expv = 65535;
`else
        expv = 0;
`endif
        if (acc_q.size() > 0) check_eq("mode1_first", acc_q[0], expv);
        for (int j = 0; j < 100 && j < acc_q.size(); j++) begin
            check_eq("mode1_seq", acc_q[j], expv);
            expv = pattern_next(eff_mode(1), expv);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            stop = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 7) == 0);
            mode = 2'($urandom_range(0, 3));
            ready_in = ($urandom_range(0, 9) < 7);
            if (i % 64 == 0) repeat_en = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 1'b0; stop = 1'b0; start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/stim_traffic_gen.md
STIM_TRAFFIC_GEN -- requirements
Module: stim_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the data beat.
REQ-002 SHALL have parameter IDLE_LEN, default 256, wait cycles before a burst (range 1..2^16).
REQ-003 SHALL have parameter BURST_LEN, default 65536, beats per burst (range 1..2^20).
REQ-004 SHALL have parameter FLAG_W, default 4, flag counter width; the flag phase lasts 2^FLAG_W cycles.
REQ-005 SHALL have parameter DIV_STAGES, default 3, number of divide-by-2^k clock-enable outputs.
REQ-006 clock  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-009 stop  in  1  synchronous abort; takes effect in any state.
REQ-010 repeat_en  in  1  when 1, FLAGS returns to WAIT instead of IDLE.
REQ-011 mode  in  2  pattern select, latched on start: 0 count, 1 LFSR, 2 walking-one, 3 count.
REQ-012 data_out  out  DATA_W  current beat.
REQ-013 valid_out  out  1  beat available.
REQ-014 ready_in  in  1  sink accepts the beat.
REQ-015 flags_out  out  FLAG_W  flag-phase counter.
REQ-016 status_out  out  8  shift register of accepted-beat parity.
REQ-017 div_en  out  DIV_STAGES  bit k pulses high one cycle in every 2^(k+1) cycles.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done_pulse  out  1  one-cycle pulse when the FLAGS phase completes.

Function
REQ-020 FSM SHALL have states IDLE, WAIT, BURST, FLAGS.
REQ-021 IDLE -> WAIT on start; WAIT -> BURST after exactly IDLE_LEN cycles in WAIT.
REQ-022 BURST -> FLAGS on the cycle the BURST_LEN-th beat is accepted.
REQ-023 FLAGS lasts 2^FLAG_W cycles; flags_out increments every cycle, wrapping to 0. On the last cycle done_pulse=1, then the FSM goes to WAIT if repeat_en=1, else IDLE.
REQ-024 A beat is accepted when valid_out && ready_in; valid_out=1 only in BURST.
REQ-025 data_out and valid_out SHALL hold stable while valid_out && !ready_in.
REQ-026 data_out SHALL advance only on acceptance:
- count mode: +1, wrapping modulo 2^DATA_W.
- LFSR mode: next Fibonacci LFSR state, seed all-ones.
- walking-one mode: rotate left, starting at 1.
REQ-027 On each acceptance, status_out SHALL shift left, inserting the XOR-reduction of the accepted data_out into bit 0.
REQ-028 stop=1 SHALL force IDLE on the next cycle: valid_out=0, counters cleared; data_out and status_out hold.
- stop has priority over start and over every FSM transition.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 The div_en counter SHALL free-run regardless of FSM state.

Reset
REQ-031 While reset=1, at the next edge all outputs SHALL be 0 except data_out, which SHALL be the mode-0 seed 0.
REQ-032 While reset=1, the FSM SHALL be in IDLE and the div_en counter SHALL be 0.
REQ-033 reset mid-burst SHALL drop valid_out the cycle after reset is sampled; no beat is accepted in that cycle.

Configuration
REQ-034 Macro STIM_TRAFFIC_GEN_LFSR_EN defined: mode 1 SHALL produce the LFSR sequence.
REQ-035 Macro STIM_TRAFFIC_GEN_LFSR_EN undefined: no LFSR logic SHALL be present and mode 1 SHALL behave as count mode.

Structure
REQ-036 Package stim_traffic_pkg SHALL hold:
- the FSM state enum;
- the mode enum;
- the LFSR tap masks for DATA_W in 8, 16, 32;
- the walking-one seed constant.
REQ-037 Sub-module stim_clk_en_div SHALL implement div_en from a DIV_STAGES-bit counter; all other logic stays in the top.

Verification
REQ-038 IDLE_LEN=4, BURST_LEN=8, ready_in=1, mode=0, start pulse at cycle 0 -> busy from cycle 1; first valid 4 cycles later; data 0..7 on consecutive cycles; flags_out 0..15; done_pulse once; then IDLE.
REQ-039 ready_in toggling 1,0,1,0 during a burst -> data_out stable during every stall; exactly 8 beats accepted; no value skipped or repeated.
REQ-040 repeat_en=1 -> after done_pulse, WAIT re-entered and a second burst continues counting from 8.
REQ-041 stop asserted at the 3rd beat of a burst, simultaneous with start -> IDLE next cycle; valid_out=0; start ignored.
REQ-042 LFSR build, DATA_W=16, mode=1 -> first beat 16'hFFFF; sequence matches reference LFSR for 100 beats. Non-LFSR build -> same stimulus gives 0,1,2...
REQ-043 Free run of 16 cycles after reset -> div_en[0] pulses 8 times, div_en[1] 4 times, div_en[2] 2 times.
